// File: rtl/mp_add_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package     : mp_add_pkg                                                    |
// | Description : Shared constants, state encoding and index-width helper for   |
// |               the multi-precision add sequencer.                            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package mp_add_pkg;

   localparam int CHUNK_W  = 16;  // width of one adder pass
   localparam int CHUNK_LG = 4;   // log2(CHUNK_W), used to form chunk bit offsets

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mp_add_state_t;

   // Width of a counter that must hold 0..n-1 (never less than one bit).
   function automatic int idx_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mp_add_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface   : mp_add_sequencer_if                                           |
// | Description : Operand and result handshake bundle of the add sequencer.     |
// |   in_valid/in_ready/in_a/in_b/in_cin : operand channel (producer -> seq)    |
// |   out_valid/out_ready/out_sum/out_cout : result channel (seq -> consumer)   |
// |   busy                                 : sequencer in RUN or DONE           |
// |   out_ovf (only with MP_ADD_OVF_EN)    : signed overflow of the result      |
// | Modports    : master (producer/consumer side), slave (sequencer side)       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface mp_add_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;
`ifdef MP_ADD_OVF_EN
   logic             out_ovf;
`endif

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MP_ADD_OVF_EN
      input  out_ovf,
`endif
      input  in_ready, out_valid, out_sum, out_cout, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MP_ADD_OVF_EN
      output out_ovf,
`endif
      output in_ready, out_valid, out_sum, out_cout, busy
   );
endinterface
`default_nettype wire

// File: rtl/mp_add_sequencer_rca16.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ripple_carry_16_bit                                           |
// | Description : 16-bit ripple-carry adder, one full adder per bit.            |
// | Ports       : i_a, i_b (16) operands; i_cin carry-in;                       |
// |               o_sum (16) sum; o_cout carry out of bit 15                    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ripple_carry_16_bit (
   input  wire logic [15:0] i_a,
   input  wire logic [15:0] i_b,
   input  wire logic        i_cin,
   output logic      [15:0] o_sum,
   output logic             o_cout
);
   logic w_carry;

   // Carry is threaded bit by bit through a scalar so the chain stays a
   // true ripple without a self-referencing carry vector.
   always_comb begin
      o_sum   = '0;
      w_carry = i_cin;
      for (int i = 0; i < 16; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
         w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_carry;
   end
endmodule
`default_nettype wire

// File: rtl/mp_add_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mp_add_sequencer                                              |
// | Description : Multi-precision adder. Accepts a WIDTH-bit operand pair and   |
// |               walks it through one 16-bit ripple adder, LSB chunk first,    |
// |               chaining the carry through a register, then presents the     |
// |               WIDTH-bit sum and carry-out on a result handshake.            |
// | Ports       : clk     clock (rising edge)                                   |
// |               rst_n   asynchronous active-low reset                         |
// |               bus     mp_add_sequencer_if.slave (operand/result channels)   |
// | Parameters  : WIDTH   operand width, multiple of 16 and >= 32               |
// | Macro       : MP_ADD_OVF_EN adds the signed-overflow output out_ovf         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module mp_add_sequencer
   import mp_add_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input wire logic          clk,
   input wire logic          rst_n,
   mp_add_sequencer_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK_W;
   localparam int IDX_W  = idx_clog2(NCHUNK);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCHUNK - 1);

   generate
      if (((WIDTH % CHUNK_W) != 0) || (WIDTH < 2 * CHUNK_W)) begin : g_width_check
         $error("mp_add_sequencer: WIDTH must be a multiple of 16 and >= 32");
      end
   endgenerate

   mp_add_state_t        r_state;
   mp_add_state_t        w_next_state;
   logic [IDX_W-1:0]     r_idx;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic                 r_carry;
   logic [WIDTH-1:0]     r_sum;
   logic                 r_cout;
   logic [IDX_W+CHUNK_LG-1:0] w_base;
   logic [CHUNK_W-1:0]   w_chunk_a;
   logic [CHUNK_W-1:0]   w_chunk_b;
   logic [CHUNK_W-1:0]   w_chunk_sum;
   logic                 w_chunk_cout;
   logic                 w_last;

   // Bit offset of the current chunk; sized exactly to address WIDTH bits.
   assign w_base    = {r_idx, {CHUNK_LG{1'b0}}};
   assign w_chunk_a = r_a[w_base +: CHUNK_W];
   assign w_chunk_b = r_b[w_base +: CHUNK_W];
   assign w_last    = (r_idx == c_LAST_IDX);

   ripple_carry_16_bit u_rca (
      .i_a    (w_chunk_a),
      .i_b    (w_chunk_b),
      .i_cin  (r_carry),
      .o_sum  (w_chunk_sum),
      .o_cout (w_chunk_cout)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (bus.in_valid)  w_next_state = RUN;
         RUN:  if (w_last)        w_next_state = DONE;
         DONE: if (bus.out_ready) w_next_state = IDLE;
         default:                 w_next_state = IDLE;
      endcase
   end

   // Handshake/status outputs depend on the state register only.
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state == RUN) || (r_state == DONE);

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.in_a;
                  r_b     <= bus.in_b;
                  r_carry <= bus.in_cin;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_sum[w_base +: CHUNK_W] <= w_chunk_sum;
               r_carry                  <= w_chunk_cout;
               if (w_last) begin
                  r_cout <= w_chunk_cout;
                  r_idx  <= '0;
               end else begin
                  r_idx  <= r_idx + 1'b1;
               end
            end
            default: begin
               // DONE: result held until the consumer takes it.
            end
         endcase
      end
   end

   assign bus.out_sum  = r_sum;
   assign bus.out_cout = r_cout;

`ifdef MP_ADD_OVF_EN
   logic r_ovf;

   // Overflow: operands agree in sign but the MSB of the final chunk differs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if ((r_state == RUN) && w_last) begin
         r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_chunk_sum[CHUNK_W-1] != r_a[WIDTH-1]);
      end
   end

   assign bus.out_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_add_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_mp_add_sequencer                                           |
// | Description : Directed self-checking bench for mp_add_sequencer (WIDTH=64). |
// |               Honours MP_ADD_OVF_EN when defined.                           |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_mp_add_sequencer;
   localparam int WIDTH = 64;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   mp_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

   mp_add_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, latency, result, handshake, return to idle.
   task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [63:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
      int cnt;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
         @(negedge clk);
         cnt = cnt + 1;
      end
      chk({tag, "_latency"}, 64'(cnt), 64'd4);
      chk({tag, "_sum"},     bus.out_sum, exp_sum);
      chk({tag, "_cout"},    64'(bus.out_cout), 64'(exp_cout));
`ifdef MP_ADD_OVF_EN
      chk({tag, "_ovf"},     64'(bus.out_ovf), 64'(exp_ovf));
`else
      if (exp_ovf) begin
         // overflow expectation only meaningful when the port exists
      end
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_idle"},     64'(bus.in_ready), 64'd1);
      chk({tag, "_sum_held"}, bus.out_sum, exp_sum);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_sum",       bus.out_sum,        64'd0);
      chk("rst_cout",      64'(bus.out_cout),  64'd0);
`ifdef MP_ADD_OVF_EN
      chk("rst_ovf",       64'(bus.out_ovf),   64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

      // Full carry ripple through all chunks
      do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
      // Carry-in plus carry into chunk 1
      do_op("cin", 64'h0000_0001_0000_FFFF, 64'h1, 1'b1, 64'h0000_0001_0001_0001, 1'b0, 1'b0);
      // No inter-chunk carries, every chunk distinct
      do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
            64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
      // Signed overflow cases (sum/cout checked in every build)
      do_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      do_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);

      // Backpressure: result held, new operands ignored
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 64'h1234_5678_9ABC_DEF0;
      bus.in_b     = 64'h1111_1111_1111_1111;
      bus.in_cin   = 1'b0;
      @(negedge clk);
      begin
         int cnt;
         cnt = 0;
         while (!bus.out_valid && cnt < 20) begin
            bus.in_a = bus.in_a + 64'h1;
            @(negedge clk);
            cnt = cnt + 1;
         end
         chk("bp_latency", 64'(cnt), 64'd4);
      end
      for (int i = 0; i < 5; i++) begin
         bus.in_a = 64'hDEAD_0000_0000_0000 + 64'(i);
         @(negedge clk);
         chk("bp_sum",       bus.out_sum,         64'h2345_6789_ABCD_F001);
         chk("bp_in_ready",  64'(bus.in_ready),   64'd0);
         chk("bp_out_valid", 64'(bus.out_valid),  64'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp_idle",  64'(bus.in_ready), 64'd1);
      chk("bp_busy",  64'(bus.busy),     64'd0);
      do_op("after_bp", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);

      // Reset in the middle of RUN
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 64'h1234_5678_9ABC_DEF0;
      bus.in_b     = 64'h1111_1111_1111_1111;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_busy",  64'(bus.busy),      64'd0);
      chk("mid_rst_sum",   bus.out_sum,        64'd0);
      chk("mid_rst_cout",  64'(bus.out_cout),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("mid_no_valid",  64'(bus.out_valid), 64'd0);
      chk("mid_in_ready",  64'(bus.in_ready),  64'd1);
      do_op("after_rst", 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
